shift_arbiter: RTL and testbench

- Shares one combinational shift unit (SLL/SRL/SRA/ROR, N-bit) among NREQ requesters.
- Each requester drives a valid/ready request channel; a round-robin arbiter grants one request per cycle.
- The shifted result is registered and returned on a single valid/ready response channel tagged with the requester index.
- Sits between the issue logic of several execution slots and the shared shift datapath. This replaces per-slot shifters.

---
 rtl/shift_arbiter.sv | 121 ++++++++++++
 tb/tb_shift_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Shared N-bit shift unit (SLL/SRL/SRA/ROR) behind a round-robin arbiter.
// One registered result per cycle, returned on a valid/ready channel tagged with the requester index.
module shift_arbiter #(
   parameter  int N    = 32,
   parameter  int NREQ = 4,
   localparam int SW   = $clog2(N),
   localparam int IW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*N-1:0]  req_data,
   input  logic [NREQ*SW-1:0] req_shamt,
   input  logic [NREQ*2-1:0]  req_op,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [N-1:0]       rsp_data,
   output logic [IW-1:0]      rsp_id,
   output logic [1:0]         rsp_op
);

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    data_q, data_d;
   logic [IW-1:0]   id_q, id_d;
   logic [1:0]      op_q, op_d;
   logic [IW-1:0]   ptr_q, ptr_d;

   logic            gnt_found;
   logic [IW-1:0]   gnt_idx;
   logic [IW-1:0]   cand;
   int              sum;
   logic            can_accept;
   logic            accept;
   logic [N-1:0]    opnd;
   logic [N-1:0]    shifted;
   logic [SW-1:0]   shamt;
   logic [1:0]      op;
   logic [2*N-1:0]  ror_w;

   // Scan from the pointer, wrapping mod NREQ (NREQ need not be a power of two).
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      sum       = 0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = int'(ptr_q) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         cand = IW'(sum);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      opnd    = req_data[int'(gnt_idx)*N +: N];
      shamt   = req_shamt[int'(gnt_idx)*SW +: SW];
      op      = req_op[int'(gnt_idx)*2 +: 2];
      ror_w   = {opnd, opnd} >> shamt;
      shifted = ror_w[N-1:0];
      case (op)
         2'b00:   shifted = opnd << shamt;
         2'b01:   shifted = opnd >> shamt;
         2'b10:   shifted = $unsigned($signed(opnd) >>> shamt);
         default: shifted = ror_w[N-1:0];
      endcase
   end

   assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
   assign accept     = gnt_found && can_accept && !rst;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      op_d    = op_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = ST_FULL;
         data_d  = shifted;
         id_d    = gnt_idx;
         op_d    = op;
         ptr_d   = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (rsp_ready) begin
         // Drain only: payload keeps its last value.
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         op_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         op_q    <= op_d;
         ptr_q   <= ptr_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;
   assign rsp_op    = op_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: vector table of single shifts, directed arbitration sequences,
// and a cycle-by-cycle grant/response scoreboard.
module tb_shift_arbiter;
   localparam int N    = 32;
   localparam int NREQ = 4;
   localparam int SW   = 5;
   localparam int IW   = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*N-1:0]  req_data;
   logic [NREQ*SW-1:0] req_shamt;
   logic [NREQ*2-1:0]  req_op;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [N-1:0]       rsp_data;
   logic [IW-1:0]      rsp_id;
   logic [1:0]         rsp_op;

   shift_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_shamt(req_shamt), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_op(rsp_op)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bit-by-bit reference shifter.
   function automatic logic [N-1:0] mshift(input logic [N-1:0] x, input int s, input logic [1:0] o);
      logic [N-1:0] r;
      r = '0;
      for (int b = 0; b < N; b++) begin
         case (o)
            2'b00: if (b - s >= 0) r[b] = x[b-s];
            2'b01: if (b + s < N) r[b] = x[b+s];
            2'b10: r[b] = (b + s < N) ? x[b+s] : x[N-1];
            default: r[b] = x[(b+s) % N];
         endcase
      end
      return r;
   endfunction

   typedef struct {
      logic [N-1:0]  data;
      logic [IW-1:0] id;
      logic [1:0]    op;
   } rsp_t;

   rsp_t            sbq[$];
   rsp_t            ent;
   logic [IW-1:0]   m_ptr;
   logic            m_full;
   int              mg;
   logic [NREQ-1:0] m_rdy;

   // Scoreboard: independent grant/occupancy model, checked on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         m_ptr  = '0;
         m_full = 1'b0;
         sbq.delete();
      end else begin
         mg = -1;
         for (int k = 0; k < NREQ; k++)
            if (mg < 0 && req_valid[(int'(m_ptr) + k) % NREQ]) mg = (int'(m_ptr) + k) % NREQ;
         m_rdy = '0;
         if (mg >= 0 && (!m_full || rsp_ready)) m_rdy[mg] = 1'b1;
         chk("sb_req_ready", req_ready, m_rdy);
         chk("sb_rsp_valid", rsp_valid, m_full);
         if (m_full) begin
            if (sbq.size() == 0) begin
               chk("sb_queue_nonempty", 0, 1);
            end else begin
               chk("sb_rsp_data", rsp_data, sbq[0].data);
               chk("sb_rsp_id", rsp_id, sbq[0].id);
               chk("sb_rsp_op", rsp_op, sbq[0].op);
               if (rsp_ready) void'(sbq.pop_front());
            end
         end
         if (m_rdy != '0) begin
            ent.data = mshift(req_data[mg*N +: N], int'(req_shamt[mg*SW +: SW]), req_op[mg*2 +: 2]);
            ent.id   = IW'(mg);
            ent.op   = req_op[mg*2 +: 2];
            sbq.push_back(ent);
            m_ptr  = IW'((mg + 1) % NREQ);
            m_full = 1'b1;
         end else if (rsp_ready) begin
            m_full = 1'b0;
         end
      end
   end

   typedef struct {
      int            idx;
      logic [N-1:0]  data;
      logic [SW-1:0] sh;
      logic [1:0]    op;
      logic [N-1:0]  exp;
   } vec_t;

   vec_t          vec[12];
   logic [N-1:0]  held;

   initial begin
      vec[0]  = '{2, 32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000};
      vec[1]  = '{2, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
      vec[2]  = '{2, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};
      vec[3]  = '{2, 32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000};
      vec[4]  = '{2, 32'hA5A5_1234, 5'd0,  2'b00, 32'hA5A5_1234};
      vec[5]  = '{2, 32'hA5A5_1234, 5'd0,  2'b01, 32'hA5A5_1234};
      vec[6]  = '{2, 32'hA5A5_1234, 5'd0,  2'b10, 32'hA5A5_1234};
      vec[7]  = '{2, 32'hA5A5_1234, 5'd0,  2'b11, 32'hA5A5_1234};
      vec[8]  = '{3, 32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000};
      vec[9]  = '{1, 32'hF000_000F, 5'd4,  2'b00, 32'h0000_00F0};
      vec[10] = '{3, 32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003};
      vec[11] = '{0, 32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456};

      rst = 1'b1; req_valid = '0; req_data = '0; req_shamt = '0; req_op = '0; rsp_ready = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_req_ready", req_ready, 0);
      step(); step();
      rst = 1'b0;

      // Round robin, all valid, no bubbles.
      for (int k = 0; k < NREQ; k++) begin
         req_data[k*N +: N]    = $urandom;
         req_shamt[k*SW +: SW] = SW'($urandom_range(0, N-1));
         req_op[k*2 +: 2]      = 2'($urandom_range(0, 3));
      end
      req_valid = 4'b1111;
      #1;
      chk("rr_first_ready", req_ready, 4'b0001);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("rr_valid", rsp_valid, 1);
         chk("rr_id", rsp_id, c % NREQ);
      end
      req_valid = '0;
      step();

      // Single-request vector table.
      for (int v = 0; v < 12; v++) begin
         req_valid = '0;
         req_data[vec[v].idx*N +: N]    = vec[v].data;
         req_shamt[vec[v].idx*SW +: SW] = vec[v].sh;
         req_op[vec[v].idx*2 +: 2]      = vec[v].op;
         req_valid[vec[v].idx]          = 1'b1;
         step();
         req_valid = '0;
         chk("vec_data", rsp_data, vec[v].exp);
         chk("vec_id", rsp_id, vec[v].idx);
         chk("vec_op", rsp_op, vec[v].op);
         step();
      end

      // Sparse 1/3 alternation with a 2-cycle idle gap that must not rotate priority.
      req_valid = 4'b1010;
      step(); chk("sparse_id0", rsp_id, 1);
      step(); chk("sparse_id1", rsp_id, 3);
      step(); chk("sparse_id2", rsp_id, 1);
      req_valid = '0;
      step(); step();
      req_valid = 4'b1010;
      step(); chk("sparse_gap_id", rsp_id, 3);
      step(); chk("sparse_id4", rsp_id, 1);
      req_valid = '0;
      step();

      // Backpressure: 3 stalled cycles, then drain and accept in the same cycle.
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      step();
      chk("bp_id", rsp_id, 2);
      held = rsp_data;
      for (int c = 0; c < 3; c++) begin
         chk("bp_ready_low", req_ready, 0);
         step();
         chk("bp_hold_valid", rsp_valid, 1);
         chk("bp_hold_id", rsp_id, 2);
         chk("bp_hold_data", rsp_data, held);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", req_ready, 4'b1000);
      step();
      chk("bp_reload_valid", rsp_valid, 1);
      chk("bp_reload_id", rsp_id, 3);
      req_valid = '0;
      step();

      // Asynchronous reset while FULL and stalled.
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      chk("mid_full", rsp_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_id", rsp_id, 0);
      chk("mid_rst_ready", req_ready, 0);
      step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("post_rst_ready", req_ready, 4'b0001);
      step();
      chk("post_rst_id", rsp_id, 0);
      req_valid = '0;
      step(); step();
      chk("sb_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
